// File: rtl/ffss_arb_if.sv
// Requester-side bundle for the shared modular-subtractor arbiter.
// The master modport belongs to the datapath controllers and the slave modport to the arbiter.
interface ffss_arb_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
);
  logic [N_REQ-1:0]     req;
  logic [N_REQ*255-1:0] a_flat;
  logic [N_REQ*255-1:0] b_flat;
  logic [N_REQ-1:0]     gnt;
  logic [N_REQ-1:0]     rsp_valid;
  logic [254:0]         rsp_data;
  logic [ID_W-1:0]      rsp_id;
  logic                 busy;

  modport master (
    output req, a_flat, b_flat,
    input  gnt, rsp_valid, rsp_data, rsp_id, busy
  );

  modport slave (
    input  req, a_flat, b_flat,
    output gnt, rsp_valid, rsp_data, rsp_id, busy
  );
endinterface

// File: rtl/ffss_arb.sv
// Round-robin arbiter that time-shares one (a - b) mod 2^255-19 subtractor among N_REQ requesters.
// Grant in cycle T, tagged response in cycle T+7, next grant no earlier than T+8.
module ffss_arb #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input logic        clk,
  input logic        rst_n,
  ffss_arb_if.slave  bus
);

  // Subtractor core latency from the start edge to done, chosen so rsp_valid lands at T+7.
  localparam int unsigned SubLat = 6;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q;
  logic [ID_W-1:0]  ptr_q;
  logic [ID_W-1:0]  cur_id_q;
  logic [254:0]     op_a_q;
  logic [254:0]     op_b_q;
  logic             start_q;
  logic [2:0]       cnt_q;
  logic [N_REQ-1:0] gnt_q;
  logic [N_REQ-1:0] rsp_valid_q;
  logic [254:0]     rsp_data_q;
  logic [ID_W-1:0]  rsp_id_q;

  logic             found;
  logic [ID_W-1:0]  sel;
  logic [ID_W-1:0]  ptr_nxt;
  int               k;

  logic [254:0]     sub_diff;
  logic [254:0]     sub_out;
  logic             sub_done;

  // Adding p is the same as subtracting 19 modulo 2^255.
  assign sub_diff = op_a_q - op_b_q;
  assign sub_out  = (op_a_q < op_b_q) ? (sub_diff - 255'd19) : sub_diff;
  assign sub_done = (cnt_q == 3'(SubLat));

  always_comb begin
    found = 1'b0;
    sel   = '0;
    k     = 0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      k = (int'(ptr_q) + i) % int'(N_REQ);
      if (!found && bus.req[k]) begin
        found = 1'b1;
        sel   = ID_W'(k);
      end
    end
    ptr_nxt = (int'(sel) == int'(N_REQ) - 1) ? '0 : sel + ID_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      cur_id_q    <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      start_q     <= 1'b0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
    end else begin
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      start_q     <= 1'b0;

      if (start_q) begin
        cnt_q <= 3'd1;
      end else if (sub_done) begin
        cnt_q <= '0;
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q + 3'd1;
      end

      unique case (state_q)
        StIdle: begin
          if (found) begin
            gnt_q    <= N_REQ'(1) << sel;
            op_a_q   <= bus.a_flat[int'(sel)*255 +: 255];
            op_b_q   <= bus.b_flat[int'(sel)*255 +: 255];
            cur_id_q <= sel;
            ptr_q    <= ptr_nxt;
            start_q  <= 1'b1;
            state_q  <= StRun;
          end
        end
        StRun: begin
          if (sub_done) begin
            rsp_data_q  <= sub_out;
            rsp_id_q    <= cur_id_q;
            rsp_valid_q <= N_REQ'(1) << cur_id_q;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_ffss_arb.sv
// Directed bench for ffss_arb: vector table of single operations plus hand-written
// sequences for round-robin wrap, back-to-back spacing and reset during an operation.
module tb_ffss_arb;

  localparam int unsigned NReq = 4;
  localparam int unsigned IdW  = 2;
  localparam logic [254:0] P   = {255{1'b1}} - 255'd18;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  ffss_arb_if #(.N_REQ(NReq), .ID_W(IdW)) bus ();

  ffss_arb #(.N_REQ(NReq), .ID_W(IdW)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   req;
    logic [254:0] a;
    logic [254:0] b;
    int           id;
    logic [254:0] exp;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [254:0] act, input logic [254:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic wait_gnt(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.gnt == '0 && n < 20);
    if (bus.gnt == '0) begin
      checks++;
      errors++;
      $display("FAIL %s timeout waiting for gnt after %0d cycles", nm, n);
    end
  endtask

  task automatic set_ops(input logic [254:0] a, input logic [254:0] b);
    for (int i = 0; i < int'(NReq); i++) begin
      bus.a_flat[i*255 +: 255] = a;
      bus.b_flat[i*255 +: 255] = b;
    end
  endtask

  // Single operation: grant, capture check, 7-cycle latency, hold-after-response check.
  task automatic run_op(input string nm, input logic [3:0] r, input logic [254:0] a,
                        input logic [254:0] b, input int id, input logic [254:0] exp);
    logic [3:0] oh;
    oh = 4'b0001 << id;
    bus.req = r;
    set_ops(a, b);
    wait_gnt(nm);
    chk({nm, " gnt"}, 255'(bus.gnt), 255'(oh));
    chk({nm, " busy_at_gnt"}, 255'(bus.busy), 255'(1));
    bus.req    = '0;
    bus.a_flat = ~bus.a_flat;
    bus.b_flat = {bus.b_flat[NReq*255-2:0], 1'b1};
    for (int c = 1; c < 7; c++) begin
      @(negedge clk);
      chk({nm, " busy_run"}, 255'(bus.busy), 255'(1));
      chk({nm, " no_early_rsp"}, 255'(bus.rsp_valid), 255'(0));
    end
    @(negedge clk);
    chk({nm, " rsp_valid"}, 255'(bus.rsp_valid), 255'(oh));
    chk({nm, " rsp_id"}, 255'(bus.rsp_id), 255'(id));
    chk({nm, " rsp_data"}, bus.rsp_data, exp);
    chk({nm, " busy_done"}, 255'(bus.busy), 255'(0));
    @(negedge clk);
    chk({nm, " rsp_pulse"}, 255'(bus.rsp_valid), 255'(0));
    chk({nm, " rsp_hold"}, bus.rsp_data, exp);
    chk({nm, " id_hold"}, 255'(bus.rsp_id), 255'(id));
    chk({nm, " no_gnt"}, 255'(bus.gnt), 255'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst gnt", 255'(bus.gnt), 255'(0));
    chk("rst rsp_valid", 255'(bus.rsp_valid), 255'(0));
    chk("rst rsp_data", bus.rsp_data, 255'(0));
    chk("rst rsp_id", 255'(bus.rsp_id), 255'(0));
    chk("rst busy", 255'(bus.busy), 255'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b1;
    bus.req    = '0;
    bus.a_flat = '0;
    bus.b_flat = '0;

    // Pointer trace from reset: 0 ->1 ->3 ->0 ->2 ->0 ->1 ->0
    vecs[0] = '{req: 4'b0001, a: 255'd10,  b: 255'd3,    id: 0, exp: 255'd7};
    vecs[1] = '{req: 4'b0100, a: 255'd3,   b: 255'd10,   id: 2, exp: P - 255'd7};
    vecs[2] = '{req: 4'b1010, a: 255'd5,   b: 255'd5,    id: 3, exp: 255'd0};
    vecs[3] = '{req: 4'b1010, a: 255'd100, b: 255'd1,    id: 1, exp: 255'd99};
    vecs[4] = '{req: 4'b1010, a: 255'd0,   b: 255'd1,    id: 3, exp: P - 255'd1};
    vecs[5] = '{req: 4'b0001, a: P - 255'd1, b: 255'd0,  id: 0, exp: P - 255'd1};
    vecs[6] = '{req: 4'b1001, a: 255'd1,   b: P - 255'd1, id: 3, exp: 255'd2};

    do_reset();
    for (int v = 0; v < 7; v++) begin
      run_op($sformatf("vec%0d", v), vecs[v].req, vecs[v].a, vecs[v].b, vecs[v].id, vecs[v].exp);
    end

    // All requesters held: grants every 8 cycles in order 0,1,2,3 then wrap to 0.
    do_reset();
    for (int i = 0; i < int'(NReq); i++) begin
      bus.a_flat[i*255 +: 255] = 255'(40 + 11 * i);
      bus.b_flat[i*255 +: 255] = 255'(i + 1);
    end
    bus.req = 4'b1111;
    wait_gnt("rr first");
    for (int g = 0; g < 5; g++) begin
      chk($sformatf("rr%0d gnt", g), 255'(bus.gnt), 255'(4'b0001 << (g % 4)));
      if (g == 4) bus.req = '0;
      repeat (7) @(negedge clk);
      chk($sformatf("rr%0d rsp_valid", g), 255'(bus.rsp_valid), 255'(4'b0001 << (g % 4)));
      chk($sformatf("rr%0d rsp_id", g), 255'(bus.rsp_id), 255'(g % 4));
      chk($sformatf("rr%0d rsp_data", g), bus.rsp_data, 255'(39 + 10 * (g % 4)));
      chk($sformatf("rr%0d no_gnt_with_rsp", g), 255'(bus.gnt), 255'(0));
      @(negedge clk);
    end
    chk("rr idle after drain", 255'(bus.gnt), 255'(0));

    // Reset 3 cycles after a grant to requester 2; the result must never appear.
    bus.req = 4'b0100;
    set_ops(255'd50, 255'd8);
    wait_gnt("mid gnt");
    chk("mid gnt", 255'(bus.gnt), 255'(4'b0100));
    bus.req = '0;
    repeat (2) @(negedge clk);
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("mid no_rsp", 255'(bus.rsp_valid), 255'(0));
      chk("mid no_busy", 255'(bus.busy), 255'(0));
    end
    run_op("post_rst", 4'b0010, 255'd10, 255'd3, 1, 255'd7);
    // Pointer restarted at 0 then advanced past 1, so 1010 now picks 3.
    run_op("post_rst_ptr", 4'b1010, 255'd9, 255'd9, 3, 255'd0);
    do_reset();
    run_op("ptr_restart", 4'b1010, 255'd20, 255'd5, 1, 255'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ffss_arb.md
Name: ffss_arb

Overview:
- Round-robin arbiter and sequencer that shares one instance of the team's 255-bit modular subtractor `ffss` (a − b mod p, p = 2^255 − 19) among N_REQ requesters, e.g. the point-add and point-double engines.
- Accepts a request and captures that requester's operands.
- Launches `ffss` with a one-cycle start, waits for its done pulse, then returns the result tagged with the requester ID.
- Sits between the scalar-multiplication datapath controllers and the shared subtractor.

Parameters:
- N_REQ, 4, number of requesters; must be ≥ 2.
- ID_W, 2, requester ID width; must equal clog2(N_REQ).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req  input  N_REQ  per-requester request level
- a_flat  input  N_REQ*255  minuends, requester i in bits [255*i+254 : 255*i]
- b_flat  input  N_REQ*255  subtrahends, same packing as a_flat
- gnt  output  N_REQ  one-hot, one-cycle pulse: request accepted, operands captured
- rsp_valid  output  N_REQ  one-hot, one-cycle pulse: result for requester i is on rsp_data
- rsp_data  output  255  (a − b) mod p for the completed request
- rsp_id  output  ID_W  index of the completed requester, valid while any rsp_valid bit is high
- busy  output  1  high whenever state ≠ IDLE

Behaviour:
- Async reset (rst_n low):
  - Outputs: gnt = 0, rsp_valid = 0, rsp_data = 0, rsp_id = 0, busy = 0.
  - Internal: state = IDLE, round-robin pointer ptr = 0, operand registers = 0, ffss start = 0.
  - Internal `ffss` instance is reset by ~rst_n.
- State machine:
  - IDLE: if any req bit is high, select the first set bit searching ptr, ptr+1, …, wrapping modulo N_REQ. On that edge:
    - gnt[sel] = 1;
    - capture a_flat/b_flat slice sel into op_a/op_b, and sel into cur_id;
    - ptr = (sel + 1) mod N_REQ;
    - ffss start = 1;
    - go to RUN.
  - IDLE with no request: gnt = 0, stay in IDLE.
  - RUN: gnt = 0, start = 0 (start is high for exactly one cycle). Hold op_a/op_b stable, because `ffss` reads its operands combinationally every cycle until done.
    - When ffss done = 1: rsp_data = ffss out, rsp_id = cur_id, rsp_valid[cur_id] = 1, go to IDLE.
  - In every cycle other than the completion edge, rsp_valid = 0. rsp_data and rsp_id hold their last value.
- Timing:
  - gnt is high in cycle T; rsp_valid is high in cycle T+7 (fixed latency).
  - The next gnt can come no earlier than T+8, i.e. the same edge that clears rsp_valid. Throughput is one operation per 8 cycles.
- Handshake:
  - A requester holds req and its operands until it sees gnt.
  - Operands are free to change from the cycle after gnt.
  - If req is still high after gnt, it is a new request and competes normally.
  - Dropping req before gnt cancels that request with no side effects.
  - Requests raised during RUN wait; they are arbitrated on the first IDLE edge.
- Arithmetic: result is correct only for a, b < p; operands ≥ p are a caller error and produce no flag.
- Simultaneous events:
  - Grant and response never coincide for the same operation.
  - rsp_valid for op k and gnt for op k+1 are in adjacent cycles, never the same cycle.
- Reset mid-operation: the in-flight result is discarded, no rsp_valid is issued, and arbitration restarts at requester 0.

Test Plan:
- req = 0001, a = 10, b = 3 → gnt = 0001 for one cycle; 7 cycles later rsp_valid = 0001, rsp_id = 0, rsp_data = 7; busy is high between the two.
- req = 0100, a = 3, b = 10 → rsp_data = 2^255 − 26 (0x7FFF…FFE6), rsp_id = 2.
- After reset, req = 1111 held with distinct operands → gnt order 0, 1, 2, 3 at cycles T, T+8, T+16, T+24, each response matching its requester; then pointer wraps and requester 0 is granted next.
- req = 1010 with ptr = 2 (after serving requester 1) → requester 3 granted before requester 1.
- Operands of the granted requester changed in the cycle after gnt → rsp_data still reflects the captured values; a-b = 0 case (a = b = 5) returns 0.
- Reset pulsed 3 cycles after gnt → no rsp_valid; all outputs 0; busy = 0. A new req = 0010 after release → gnt = 0010, correct result 7 cycles later.
